v_receiver_vc_buf: RTL

Parametrised testbench sink for one router outport, succeeding the single-stage receiver. Buffers incoming flits in per-VC FIFOs and drains them to the scoreboard over a true valid/ready handshake. Returns the VC credit only when a flit leaves the buffer, after a programmable delay. A drain-mode control (free-run, hold, pseudo-random stall) lets benches exercise router backpressure and credit starvation.

---
 rtl/v_noc_pkg.sv | 45 ++++
 rtl/v_receiver_vc_buf_fifo.sv | 69 ++++++
 rtl/v_receiver_vc_buf.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/v_noc_pkg.sv
// v_noc_pkg: shared NoC receiver types
// flit layout, scoreboard record, drain modes, header decoder
package v_noc_pkg;

  localparam int VC_ID_NUM_MAX_W  = 3;
  localparam int NODE_ID_W        = 4;
  localparam int TXN_ID_W         = 8;
  localparam int IO_PORT_W        = 3;
  localparam int FLIT_LENGTH      = 256;
  localparam int FLIT_DATA_LENGTH = 128;
  localparam bit ENABLE_TXN_ID    = 1'b1;

  typedef logic [NODE_ID_W-1:0] node_id_t;
  typedef logic [IO_PORT_W-1:0] io_port_t;
  typedef logic [TXN_ID_W-1:0]  txn_id_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    HOLD = 2'd1,
    RAND = 2'd2
  } v_rx_drain_mode_e;

  typedef struct packed {
    node_id_t                    rec_id;
    node_id_t                    src_id;
    txn_id_t                     txn_id;
    logic [FLIT_DATA_LENGTH-1:0] flit_data;
  } receiver_info_t;

  typedef struct packed {
    node_id_t src_id;
    txn_id_t  txn_id;
  } flit_hdr_t;

  // header lives in the low bits: src_id, then txn_id
  function automatic flit_hdr_t input_port_flit_decoder(
    input logic [FLIT_LENGTH-1:0] flit
  );
    flit_hdr_t h;
    h.src_id = flit[NODE_ID_W-1:0];
    h.txn_id = ENABLE_TXN_ID ? flit[NODE_ID_W +: TXN_ID_W] : '0;
    return h;
  endfunction

endpackage

// File: rtl/v_receiver_vc_buf_fifo.sv
// v_rx_vc_fifo: single-VC circular FIFO
// push into a full FIFO is legal only together with a pop
module v_rx_vc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem_q[rd_q];
  assign full  = (int'(cnt_q) == DEPTH);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // pointer, storage and occupancy update
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = inc(wr_q);
    end
    if (pop) rd_d = inc(rd_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/v_receiver_vc_buf.sv
// v_receiver_vc_buf: per-VC buffered NoC sink
// RR drain to scoreboard, delayed credit on dequeue
module v_receiver_vc_buf
  import v_noc_pkg::*;
#(
  parameter type flit_payload_t = logic [FLIT_LENGTH-1:0],
  parameter int  VC_NUM         = 4,
  parameter int  VC_DEPTH       = 4,
  parameter int  CREDIT_DELAY   = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rx_flit_pend_i,
  input  logic                       rx_flit_v_i,
  input  flit_payload_t              rx_flit_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] rx_flit_vc_id_i,
  input  io_port_t                   rx_flit_look_ahead_routing_i,
  output logic                       rx_lcrd_v_o,
  output logic [VC_ID_NUM_MAX_W-1:0] rx_lcrd_id_o,
  output logic                       check_scoreboard_vld_o,
  output receiver_info_t             check_scoreboard_o,
  input  logic                       check_scoreboard_rdy_i,
  input  logic [1:0]                 drain_mode_i,
  input  logic [7:0]                 stall_thresh_i,
  input  node_id_t                   node_id_i,
  output logic [VC_NUM*($clog2(VC_DEPTH)+1)-1:0] vc_occ_o,
  output logic [31:0]                rx_flit_cnt_o,
  output logic                       err_overflow_o,
  output logic                       err_bad_vc_o
);

  localparam int CW = $clog2(VC_DEPTH) + 1;
  localparam int FW = $bits(flit_payload_t);
  localparam int EW = FW + IO_PORT_W;
  localparam int IW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int D  = CREDIT_DELAY;

  logic [EW-1:0]     wdata;
  logic [EW-1:0]     rdata [VC_NUM];
  logic [VC_NUM-1:0] hit, push, pop, full, empty;
  logic              vc_ok, found, start_ok, vld, hs;
  logic [IW-1:0]     pick, cur_vc;
  logic [EW-1:0]     head;
  flit_hdr_t         hdr;
  receiver_info_t    info;

  logic          pres_q, pres_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic [D-1:0]  crv_q, crv_d;
  logic [D-1:0][VC_ID_NUM_MAX_W-1:0] cri_q, cri_d;

  assign vc_ok = (int'(rx_flit_vc_id_i) < VC_NUM);
  assign wdata = {rx_flit_i, rx_flit_look_ahead_routing_i};

  for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
    assign hit[i]  = rx_flit_v_i && vc_ok
                   && (int'(rx_flit_vc_id_i) == i);
    assign push[i] = hit[i] && (!full[i] || pop[i]);
    assign pop[i]  = hs && (int'(cur_vc) == i);
    v_rx_vc_fifo #(
      .W     (EW),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (wdata),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (vc_occ_o[i*CW +: CW])
    );
  end

  // round-robin search for a non-empty VC from rr_q
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < VC_NUM; k++) begin
      j = int'(rr_q) + k;
      if (j >= VC_NUM) j = j - VC_NUM;
      if (!found && !empty[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  // drain gating for starting a new presentation
  always_comb begin
    start_ok = 1'b1;
    case (v_rx_drain_mode_e'(drain_mode_i))
      HOLD:    start_ok = 1'b0;
      RAND:    start_ok = (lfsr_q >= stall_thresh_i);
      default: start_ok = 1'b1;
    endcase
  end

  assign vld    = pres_q || (found && start_ok);
  assign cur_vc = pres_q ? sel_q : pick;
  assign hs     = vld && check_scoreboard_rdy_i;

  // head decode into the scoreboard record
  always_comb begin
    head           = rdata[cur_vc];
    hdr            = input_port_flit_decoder(head[EW-1 -: FLIT_LENGTH]);
    info.rec_id    = node_id_i;
    info.src_id    = hdr.src_id;
    info.txn_id    = hdr.txn_id;
    info.flit_data = head[EW-1 -: FLIT_DATA_LENGTH];
  end

  logic unused_bits;
  assign unused_bits = ^{rx_flit_pend_i, head};

  assign check_scoreboard_vld_o = vld;
  assign check_scoreboard_o     = vld ? info : '0;
  assign rx_lcrd_v_o            = crv_q[D-1];
  assign rx_lcrd_id_o           = cri_q[D-1];
  assign rx_flit_cnt_o          = cnt_q;
  assign err_overflow_o         = ovf_q;
  assign err_bad_vc_o           = bad_q;

  // hold/advance selection, lfsr, counters, credit pipe
  always_comb begin
    pres_d = pres_q;
    sel_d  = sel_q;
    rr_d   = rr_q;
    if (hs) begin
      pres_d = 1'b0;
      rr_d   = (int'(cur_vc) == VC_NUM - 1) ? '0 : cur_vc + 1'b1;
    end else if (vld) begin
      pres_d = 1'b1;
      sel_d  = cur_vc;
    end
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cnt_d  = cnt_q + 32'(|push);
    ovf_d  = ovf_q | (|(hit & full & ~pop));
    bad_d  = bad_q | (rx_flit_v_i && !vc_ok);
    crv_d  = crv_q;
    cri_d  = cri_q;
    for (int k = D - 1; k >= 1; k--) begin
      crv_d[k] = crv_q[k-1];
      cri_d[k] = cri_q[k-1];
    end
    crv_d[0] = hs;
    cri_d[0] = VC_ID_NUM_MAX_W'(cur_vc);
  end

  // state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pres_q <= 1'b0;
      sel_q  <= '0;
      rr_q   <= '0;
      lfsr_q <= 8'hA5;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      bad_q  <= 1'b0;
      crv_q  <= '0;
      cri_q  <= '0;
    end else begin
      pres_q <= pres_d;
      sel_q  <= sel_d;
      rr_q   <= rr_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      bad_q  <= bad_d;
      crv_q  <= crv_d;
      cri_q  <= cri_d;
    end
  end

endmodule
